// File: rtl/linear_op_emitter_pkg.sv
// Shared types for the linear op emitter: ASCII constants, FSM state enum, command limit.
// Default widths are provided here when the surrounding build does not define them.
`ifndef OP_ARG_BITS
`define OP_ARG_BITS 16
`endif
`ifndef OP_CMD_BITS
`define OP_CMD_BITS 8
`endif
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

package linear_op_emitter_pkg;

   typedef logic [`BYTE_BITS-1:0] char_t;

   localparam char_t CHAR_G     = char_t'(8'h47);
   localparam char_t CHAR_X     = char_t'(8'h58);
   localparam char_t CHAR_Y     = char_t'(8'h59);
   localparam char_t CHAR_SPACE = char_t'(8'h20);
   localparam char_t CHAR_MINUS = char_t'(8'h2d);
   localparam char_t CHAR_ZERO  = char_t'(8'h30);
   localparam char_t CHAR_LF    = char_t'(8'h0a);
   localparam char_t CHAR_CR    = char_t'(8'h0d);

   localparam int MAX_CMD_EMIT = 99;

   typedef enum logic [4:0] {
      IDLE,
      CMD_CONV,
      EMIT_G,
      EMIT_CT,
      EMIT_CO,
      EMIT_SP1,
      X_CONV,
      EMIT_X,
      X_SIGN,
      X_DIG,
      EMIT_SP2,
      Y_CONV,
      EMIT_Y,
      Y_SIGN,
      Y_DIG,
      EMIT_NL,
`ifdef LINEAR_EMITTER_CRLF_EN
      EMIT_CR,
`endif
      DONE
   } linear_emitter_state_t;

   function automatic char_t digit_char(input logic [3:0] d);
      return CHAR_ZERO + char_t'(d);
   endfunction

endpackage

// File: rtl/linear_op_emitter_bin_to_bcd.sv
// Sequential double-dabble: BITS enabled cycles from start to done, one shift per clk_en cycle.
// Result and top non-zero digit index stay valid after done until the next start.
module bin_to_bcd_seq #(
   parameter int BITS   = 16,
   parameter int DIGITS = 5,
   parameter int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clk_en,
   input  logic                start,
   input  logic [BITS-1:0]     bin,
   output logic                done,
   output logic [DIGITS*4-1:0] bcd,
   output logic [IDX_W-1:0]    top_idx
);

   localparam int CNT_W = $clog2(BITS + 1);

   logic [BITS-1:0]     shift_q, shift_d;
   logic [DIGITS*4-1:0] bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      shift_d = shift_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = done_q;
      if (clk_en) begin
         if (start && !busy_q) begin
            shift_d = bin;
            bcd_d   = '0;
            cnt_d   = CNT_W'(BITS);
            busy_d  = 1'b1;
            done_d  = 1'b0;
         end else if (busy_q) begin
            {bcd_d, shift_d} = {bcd_adj[DIGITS*4-2:0], shift_q, 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
         end
      end
   end

   // A value of zero reports index 0 so the caller still emits a single '0'.
   always_comb begin
      top_idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] != 4'd0) top_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: rtl/linear_op_emitter.sv
// Serialises a linear op (cmd, X, Y) to ASCII "Gcc X.. Y..\n", one registered byte per char_rdy transfer.
// Output byte held while char_rdy is low; LINEAR_EMITTER_CRLF_EN switches the terminator to "\r\n".
module linear_op_emitter
   import linear_op_emitter_pkg::*;
#(
   parameter int ARG_BITS   = `OP_ARG_BITS,
   parameter int CMD_BITS   = `OP_CMD_BITS,
   parameter int MAX_DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_en,
   input  logic                  trigger,
   input  logic [CMD_BITS-1:0]   cmd,
   input  logic [ARG_BITS-1:0]   arg_x,
   input  logic [ARG_BITS-1:0]   arg_y,
   output logic                  rdy,
   output logic                  done,
   output logic                  error,
   output logic [`BYTE_BITS-1:0] char_out,
   output logic                  char_valid,
   input  logic                  char_rdy
);

   localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

   linear_emitter_state_t  state_q, state_d;
   logic [ARG_BITS-1:0]    arg_x_q, arg_x_d;
   logic [ARG_BITS-1:0]    arg_y_q, arg_y_d;
   logic                   err_q, err_d;
   logic [3:0]             cmd_tens_q, cmd_tens_d;
   logic [3:0]             cmd_ones_q, cmd_ones_d;
   logic [MAX_DIGITS*4-1:0] num_bcd_q, num_bcd_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   rdy_q, rdy_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;
   char_t                  char_out_q, char_out_d;
   logic                   char_valid_q, char_valid_d;

   logic                   conv_start;
   logic [ARG_BITS-1:0]    conv_bin;
   logic                   conv_done;
   logic [MAX_DIGITS*4-1:0] conv_bcd;
   logic [IDX_W-1:0]       conv_top;
   logic [ARG_BITS-1:0]    mag_x, mag_y;
   logic                   xfer;

   // Unsigned magnitude keeps the most negative value exact.
   assign mag_x = arg_x_q[ARG_BITS-1] ? (~arg_x_q + ARG_BITS'(1)) : arg_x_q;
   assign mag_y = arg_y_q[ARG_BITS-1] ? (~arg_y_q + ARG_BITS'(1)) : arg_y_q;
   assign xfer  = char_valid_q & char_rdy;

   bin_to_bcd_seq #(
      .BITS   (ARG_BITS),
      .DIGITS (MAX_DIGITS),
      .IDX_W  (IDX_W)
   ) u_conv (
      .clk     (clk),
      .reset   (reset),
      .clk_en  (clk_en),
      .start   (conv_start),
      .bin     (conv_bin),
      .done    (conv_done),
      .bcd     (conv_bcd),
      .top_idx (conv_top)
   );

   function automatic logic is_emit(input linear_emitter_state_t s);
      case (s)
         EMIT_G, EMIT_CT, EMIT_CO, EMIT_SP1, EMIT_X, X_SIGN, X_DIG,
         EMIT_SP2, EMIT_Y, Y_SIGN, Y_DIG, EMIT_NL: return 1'b1;
`ifdef LINEAR_EMITTER_CRLF_EN
         EMIT_CR: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      arg_x_d    = arg_x_q;
      arg_y_d    = arg_y_q;
      err_d      = err_q;
      cmd_tens_d = cmd_tens_q;
      cmd_ones_d = cmd_ones_q;
      num_bcd_d  = num_bcd_q;
      idx_d      = idx_q;
      conv_start = 1'b0;
      conv_bin   = ARG_BITS'(cmd);

      if (clk_en) begin
         unique case (state_q)
            IDLE: if (trigger) begin
               arg_x_d = arg_x;
               arg_y_d = arg_y;
               if (32'(cmd) > MAX_CMD_EMIT) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  err_d      = 1'b0;
                  conv_start = 1'b1;
                  state_d    = CMD_CONV;
               end
            end
            // X conversion runs underneath the G/cmd/space bytes.
            CMD_CONV: if (conv_done) begin
               cmd_tens_d = conv_bcd[7:4];
               cmd_ones_d = conv_bcd[3:0];
               conv_bin   = mag_x;
               conv_start = 1'b1;
               state_d    = EMIT_G;
            end
            EMIT_G:   if (xfer) state_d = EMIT_CT;
            EMIT_CT:  if (xfer) state_d = EMIT_CO;
            EMIT_CO:  if (xfer) state_d = EMIT_SP1;
            EMIT_SP1: if (xfer) state_d = X_CONV;
            X_CONV: if (conv_done) begin
               num_bcd_d  = conv_bcd;
               idx_d      = conv_top;
               conv_bin   = mag_y;
               conv_start = 1'b1;
               state_d    = EMIT_X;
            end
            EMIT_X: if (xfer) state_d = arg_x_q[ARG_BITS-1] ? X_SIGN : X_DIG;
            X_SIGN: if (xfer) state_d = X_DIG;
            X_DIG: if (xfer) begin
               if (idx_q == '0) state_d = EMIT_SP2;
               else             idx_d   = idx_q - IDX_W'(1);
            end
            EMIT_SP2: if (xfer) state_d = Y_CONV;
            Y_CONV: if (conv_done) begin
               num_bcd_d = conv_bcd;
               idx_d     = conv_top;
               state_d   = EMIT_Y;
            end
            EMIT_Y: if (xfer) state_d = arg_y_q[ARG_BITS-1] ? Y_SIGN : Y_DIG;
            Y_SIGN: if (xfer) state_d = Y_DIG;
            Y_DIG: if (xfer) begin
               if (idx_q == '0) begin
`ifdef LINEAR_EMITTER_CRLF_EN
                  state_d = EMIT_CR;
`else
                  state_d = EMIT_NL;
`endif
               end else begin
                  idx_d = idx_q - IDX_W'(1);
               end
            end
`ifdef LINEAR_EMITTER_CRLF_EN
            EMIT_CR: if (xfer) state_d = EMIT_NL;
`endif
            EMIT_NL: if (xfer) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      // Outputs are registered from next-state values, so a stalled byte is recomputed unchanged.
      rdy_d        = (state_d == IDLE);
      done_d       = (state_d == DONE);
      error_d      = (state_d == DONE) && err_d;
      char_valid_d = is_emit(state_d);
      case (state_d)
         EMIT_G:           char_out_d = CHAR_G;
         EMIT_CT:          char_out_d = digit_char(cmd_tens_d);
         EMIT_CO:          char_out_d = digit_char(cmd_ones_d);
         EMIT_SP1, EMIT_SP2: char_out_d = CHAR_SPACE;
         EMIT_X:           char_out_d = CHAR_X;
         EMIT_Y:           char_out_d = CHAR_Y;
         X_SIGN, Y_SIGN:   char_out_d = CHAR_MINUS;
         X_DIG, Y_DIG:     char_out_d = digit_char(num_bcd_d[{idx_d, 2'b00} +: 4]);
`ifdef LINEAR_EMITTER_CRLF_EN
         EMIT_CR:          char_out_d = CHAR_CR;
`endif
         EMIT_NL:          char_out_d = CHAR_LF;
         default:          char_out_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         arg_x_q      <= '0;
         arg_y_q      <= '0;
         err_q        <= 1'b0;
         cmd_tens_q   <= '0;
         cmd_ones_q   <= '0;
         num_bcd_q    <= '0;
         idx_q        <= '0;
         rdy_q        <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         char_out_q   <= '0;
         char_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         arg_x_q      <= arg_x_d;
         arg_y_q      <= arg_y_d;
         err_q        <= err_d;
         cmd_tens_q   <= cmd_tens_d;
         cmd_ones_q   <= cmd_ones_d;
         num_bcd_q    <= num_bcd_d;
         idx_q        <= idx_d;
         rdy_q        <= rdy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         char_out_q   <= char_out_d;
         char_valid_q <= char_valid_d;
      end
   end

   assign rdy        = rdy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign char_out   = char_out_q;
   assign char_valid = char_valid_q;

endmodule

// File: tb/tb_linear_op_emitter.sv
// Self-checking bench for linear_op_emitter: expected lines come from $sformatf on the op values.
module tb_linear_op_emitter;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        trigger;
   logic [7:0]  cmd;
   logic [15:0] arg_x;
   logic [15:0] arg_y;
   logic        rdy;
   logic        done;
   logic        error;
   logic [7:0]  char_out;
   logic        char_valid;
   logic        char_rdy;

   int          n_checks = 0;
   int          n_fail   = 0;

   logic [7:0]  got[$];
   int          done_cnt;
   int          err_cnt;
   int          stab_viol;
   int          trig_wait;
   bit          timed_out;
   logic        rdy_after_trig;

   always #5 clk = ~clk;

   linear_op_emitter #(
      .ARG_BITS   (16),
      .CMD_BITS   (8),
      .MAX_DIGITS (5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_en     (clk_en),
      .trigger    (trigger),
      .cmd        (cmd),
      .arg_x      (arg_x),
      .arg_y      (arg_y),
      .rdy        (rdy),
      .done       (done),
      .error      (error),
      .char_out   (char_out),
      .char_valid (char_valid),
      .char_rdy   (char_rdy)
   );

   function automatic string exp_line(input int c, input logic signed [15:0] x,
                                      input logic signed [15:0] y);
      string term;
`ifdef LINEAR_EMITTER_CRLF_EN
      term = "\r\n";
`else
      term = "\n";
`endif
      return $sformatf("G%02d X%0d Y%0d%s", c, x, y, term);
   endfunction

   function automatic string got_str();
      string r = "";
      foreach (got[i]) r = $sformatf("%s%c", r, got[i]);
      return r;
   endfunction

   function automatic string show(input string s);
      string r = "";
      for (int i = 0; i < s.len(); i++) begin
         if (s[i] == 8'h0a)      r = {r, "\\n"};
         else if (s[i] == 8'h0d) r = {r, "\\r"};
         else                    r = $sformatf("%s%c", r, s[i]);
      end
      return r;
   endfunction

   // Triggers one op, then samples every negedge until done is seen or the budget runs out.
   task automatic run_line(input logic [7:0] c, input logic [15:0] x, input logic [15:0] y,
                           input bit stall, input bit mid_trig, input int budget);
      bit         armed = 0;
      bit         fin = 0;
      bit         mid_done = 0;
      logic       held_vld = 0;
      logic [7:0] held = 0;
      logic       xfer;
      got.delete();
      done_cnt = 0; err_cnt = 0; stab_viol = 0; trig_wait = 0; timed_out = 0;
      cmd = c; arg_x = x; arg_y = y;
      for (int i = 0; i < 64 && !armed; i++) begin
         @(posedge clk); #2;
         clk_en = 1'b1; char_rdy = 1'b1;
         if (rdy) begin
            trigger = 1'b1;
            armed = 1;
         end else begin
            trig_wait++;
         end
      end
      if (!armed) timed_out = 1;
      for (int i = 0; i < budget && armed && !fin; i++) begin
         @(posedge clk); #2;
         trigger = 1'b0;
         if (stall) begin
            clk_en   = ($urandom_range(0, 2) == 0);
            char_rdy = 1'($urandom_range(0, 1));
         end else begin
            clk_en = 1'b1; char_rdy = 1'b1;
         end
         if (mid_trig && !mid_done && got.size() == 5) begin
            trigger = 1'b1; cmd = 8'd7; arg_x = 16'd5; arg_y = 16'd6;
            mid_done = 1;
         end
         @(negedge clk);
         if (i == 0) rdy_after_trig = rdy;
         if (held_vld && (!char_valid || char_out !== held)) stab_viol++;
         xfer = char_valid & char_rdy & clk_en;
         if (xfer) got.push_back(char_out);
         held_vld = char_valid & ~xfer;
         held = char_out;
         if (done && clk_en) begin
            done_cnt++;
            if (error) err_cnt++;
            fin = 1;
         end
      end
      if (armed && !fin) timed_out = 1;
      trigger = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; clk_en = 1'b1; trigger = 1'b0; char_rdy = 1'b1;
      cmd = '0; arg_x = '0; arg_y = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (rdy !== 1'b1)        begin n_fail++; $display("FAIL reset_rdy: got %b required 1", rdy); end
      n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
      n_checks++; if (error !== 1'b0)      begin n_fail++; $display("FAIL reset_error: got %b required 0", error); end
      n_checks++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", char_valid); end
      n_checks++; if (char_out !== 8'h00)  begin n_fail++; $display("FAIL reset_char: got %h required 00", char_out); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      string e = exp_line(1, 16'sd12, 16'sd340);
      int extra = 0;
      run_line(8'd1, 16'd12, 16'd340, 0, 0, 600);
      n_checks++; if (got_str() != e) begin n_fail++; $display("FAIL basic_stream: got \"%s\" required \"%s\"", show(got_str()), show(e)); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done: got %0d required 1", done_cnt); end
      n_checks++; if (err_cnt !== 0)  begin n_fail++; $display("FAIL basic_error: got %0d required 0", err_cnt); end
      n_checks++; if (rdy_after_trig !== 1'b0) begin n_fail++; $display("FAIL basic_rdy_drop: got %b required 0", rdy_after_trig); end
      @(negedge clk);
      n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL basic_rdy_after_done: got %b required 1", rdy); end
      repeat (4) begin @(negedge clk); if (done) extra++; end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL basic_extra_done: got %0d required 0", extra); end
   endtask

   task automatic test_zero_neg();
      string e = exp_line(0, 16'sd0, -16'sd1);
      run_line(8'd0, 16'd0, 16'hffff, 0, 0, 600);
      n_checks++; if (got_str() != e) begin n_fail++; $display("FAIL zero_stream: got \"%s\" required \"%s\"", show(got_str()), show(e)); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done: got %0d required 1", done_cnt); end
   endtask

   task automatic test_extremes();
      string e = exp_line(1, -16'sd32768, 16'sd32767);
      run_line(8'd1, 16'h8000, 16'h7fff, 0, 0, 600);
      n_checks++; if (got_str() != e) begin n_fail++; $display("FAIL extreme_stream: got \"%s\" required \"%s\"", show(got_str()), show(e)); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL extreme_done: got %0d required 1", done_cnt); end
   endtask

   task automatic test_stall();
      string e = exp_line(1, 16'sd12, 16'sd340);
      run_line(8'd1, 16'd12, 16'd340, 1, 0, 4000);
      n_checks++; if (got_str() != e) begin n_fail++; $display("FAIL stall_stream: got \"%s\" required \"%s\"", show(got_str()), show(e)); end
      n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d violations required 0", stab_viol); end
      n_checks++; if (done_cnt !== 1)  begin n_fail++; $display("FAIL stall_done: got %0d required 1", done_cnt); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         logic [7:0]  c = 8'($urandom_range(0, 99));
         logic [15:0] x = 16'($urandom);
         logic [15:0] y = 16'($urandom);
         bit          st = 1'($urandom_range(0, 1));
         string       e;
         if (k == 0) x = 16'd0;
         if (k == 1) y = 16'h8000;
         e = exp_line(c, x, y);
         run_line(c, x, y, st, 0, 4000);
         n_checks++; if (got_str() != e) begin n_fail++; $display("FAIL rand_stream[%0d]: got \"%s\" required \"%s\"", k, show(got_str()), show(e)); end
         n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL rand_hold[%0d]: got %0d violations required 0", k, stab_viol); end
         n_checks++; if (done_cnt !== 1 || err_cnt !== 0) begin n_fail++; $display("FAIL rand_done[%0d]: got done %0d err %0d required 1/0", k, done_cnt, err_cnt); end
      end
   endtask

   task automatic test_reset_midline();
      int  n = 0;
      int  dn = 0;
      bit  hit = 0;
      bit  armed = 0;
      string e = exp_line(1, 16'sd12, 16'sd340);
      cmd = 8'd1; arg_x = 16'd12; arg_y = 16'd340;
      for (int i = 0; i < 64 && !armed; i++) begin
         @(posedge clk); #2;
         clk_en = 1'b1; char_rdy = 1'b1;
         if (rdy) begin trigger = 1'b1; armed = 1; end
      end
      @(posedge clk); #2;
      trigger = 1'b0;
      for (int i = 0; i < 600 && !hit; i++) begin
         @(negedge clk);
         if (char_valid && char_rdy && clk_en) n++;
         if (n == 4) hit = 1;
      end
      n_checks++; if (!hit) begin n_fail++; $display("FAIL midreset_reach4: got %0d transfers required 4", n); end
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b required 0", char_valid); end
      n_checks++; if (rdy !== 1'b1)        begin n_fail++; $display("FAIL midreset_rdy: got %b required 1", rdy); end
      reset = 1'b0;
      repeat (6) begin @(negedge clk); if (done) dn++; end
      n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d required 0", dn); end
      run_line(8'd1, 16'd12, 16'd340, 0, 0, 600);
      n_checks++; if (got_str() != e) begin n_fail++; $display("FAIL midreset_restart: got \"%s\" required \"%s\"", show(got_str()), show(e)); end
   endtask

   task automatic test_bad_cmd();
      run_line(8'd100, 16'd12, 16'd340, 0, 0, 100);
      n_checks++; if (got.size() !== 0) begin n_fail++; $display("FAIL bad100_bytes: got %0d required 0", got.size()); end
      n_checks++; if (done_cnt !== 1 || err_cnt !== 1) begin n_fail++; $display("FAIL bad100_done_err: got done %0d err %0d required 1/1", done_cnt, err_cnt); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL bad100_pulse: got done %b error %b required 0/0", done, error); end
      run_line(8'd255, 16'hffff, 16'd1, 0, 0, 100);
      n_checks++; if (got.size() !== 0 || err_cnt !== 1) begin n_fail++; $display("FAIL bad255: got %0d bytes err %0d required 0/1", got.size(), err_cnt); end
   endtask

   task automatic test_mid_trigger();
      string e = exp_line(1, 16'sd12, 16'sd340);
      int extra = 0;
      run_line(8'd1, 16'd12, 16'd340, 0, 1, 600);
      n_checks++; if (got_str() != e) begin n_fail++; $display("FAIL midtrig_stream: got \"%s\" required \"%s\"", show(got_str()), show(e)); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL midtrig_done: got %0d required 1", done_cnt); end
      repeat (4) begin @(negedge clk); if (done || char_valid) extra++; end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL midtrig_second_line: got %0d active cycles required 0", extra); end
   endtask

   task automatic test_back_to_back();
      string e1 = exp_line(42, -16'sd7, 16'sd0);
      string e2 = exp_line(3, 16'sd9, -16'sd10000);
      run_line(8'd42, 16'hfff9, 16'd0, 0, 0, 600);
      n_checks++; if (got_str() != e1) begin n_fail++; $display("FAIL b2b_first: got \"%s\" required \"%s\"", show(got_str()), show(e1)); end
      run_line(8'd3, 16'd9, 16'(-10000), 0, 0, 600);
      n_checks++; if (trig_wait !== 0) begin n_fail++; $display("FAIL b2b_accept: got %0d wait cycles required 0", trig_wait); end
      n_checks++; if (got_str() != e2) begin n_fail++; $display("FAIL b2b_second: got \"%s\" required \"%s\"", show(got_str()), show(e2)); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_neg();
      test_extremes();
      test_stall();
      test_random();
      test_reset_midline();
      test_bad_cmd();
      test_mid_trigger();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
